regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Parametrised write-back register file for the Y86 datapath.
- Decodes the E and M write-back ports and stores the architectural registers.
- Provides two combinational read ports with optional same-cycle write bypass.
- Detects and counts same-register write conflicts.
- Replaces the discrete per-register enable/data fan-out plus external registers with one clocked block.

Parameters:
- DATA_W, 32: register data width in bits.
- ADDR_W, 3: register-ID width of all dst/src ports.
- NREGS, 8: number of implemented registers; must satisfy 1 <= NREGS <= 2**ADDR_W. Any ID >= NREGS is "none".
- PRIO_M, 1: same-dst conflict winner; 1 = M port wins, 0 = E port wins.
- BYPASS, 1: 1 = read ports return same-cycle write data (write-first); 0 = read ports return stored value only.
- CNT_W, 16: width of the conflict counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- dstE  in  ADDR_W  E-port destination ID.
- reqE  in  1  E-port write request.
- valE  in  DATA_W  E-port write data.
- dstM  in  ADDR_W  M-port destination ID.
- reqM  in  1  M-port write request.
- valM  in  DATA_W  M-port write data.
- srcA  in  ADDR_W  read port A register ID.
- valA  out  DATA_W  read port A data (combinational).
- srcB  in  ADDR_W  read port B register ID.
- valB  out  DATA_W  read port B data (combinational).
- conflict  out  1  registered one-cycle pulse: a same-dst double write was committed.
- conflict_cnt  out  CNT_W  saturating count of committed conflicts.

Behaviour:
- Reset: on a rising clk edge with rst=1:
  - all NREGS registers become 0;
  - conflict becomes 0 and conflict_cnt becomes 0;
  - any write presented in that cycle is discarded;
  - with BYPASS=1, valA/valB still show same-cycle write data during the reset cycle, because bypass is combinational.
- Effective enable:
  - weE = reqE & (dstE < NREGS);
  - weM = reqM & (dstM < NREGS);
  - a request to a "none" ID is ignored completely: no write, no bypass, no conflict.
- Commit: on each rising edge with rst=0, register[dstE] <= valE if weE and register[dstM] <= valM if weM. Write latency is 1 cycle, i.e. the stored value is visible from the next cycle.
- Different destinations: when weE and weM target different IDs, both writes commit in the same cycle.
- Conflict (weE & weM & dstE==dstM):
  - only the winner's data is written (M if PRIO_M=1, else E);
  - at that edge conflict <= 1 and conflict_cnt <= conflict_cnt+1;
  - conflict_cnt saturates at 2**CNT_W-1 and never wraps.
- No conflict: conflict <= 0 at the edge; conflict_cnt is held.
- Reads, combinational:
  - srcX >= NREGS -> valX = 0;
  - BYPASS=1 and srcX matches an effective write -> valX = the data that will commit, applying the same conflict priority;
  - otherwise valX = the stored register value.
- Both read ports are independent; srcA==srcB is legal.
- No X propagation: all outputs are defined from the first edge with rst=1.

Decomposition:
- Shared package y86_regs_pkg:
  - constants RNONE (all-ones ADDR_W), REG_ESP, REG_EBP and the other Y86 register IDs;
  - default DATA_W and ADDR_W localparams.
- One natural sub-module, wb_port_decode:
  - inputs dst, req; output NREGS-bit one-hot enable vector with the "none" ID masked;
  - instantiated once for E and once for M.
- Priority, bypass muxing and the counter stay in regfile_wb.

Test Plan:
- Reset: preload all 8 registers with 0xA5A5_0000+i, then assert rst for one cycle with reqE=1 dstE=2 valE=0x1234 -> next cycle every read returns 0, register 2 is 0, conflict=0, conflict_cnt=0.
- Dual write: reqE=1 dstE=1 valE=0x11; reqM=1 dstM=4 valM=0x44 -> next cycle srcA=1 gives 0x11, srcB=4 gives 0x44, conflict=0.
- Conflict, PRIO_M=1: reqE=1 reqM=1, dstE=dstM=4, valE=0xE, valM=0xD -> same cycle srcA=4 gives 0xD (BYPASS=1); after the edge register 4=0xD, conflict=1 for exactly one cycle, conflict_cnt=1. Repeat with PRIO_M=0 -> 0xE.
- None ID (ADDR_W=4, NREGS=15): reqE=1 dstE=0xF valE=0xFFFF -> no register changes; srcA=0xF reads 0; conflict stays 0.
- Bypass off: BYPASS=0, register 3 holds 0x7, write dstE=3 valE=0x9 -> same cycle srcA=3 reads 0x7; next cycle reads 0x9.
- Saturation: CNT_W=2, apply 5 consecutive conflict cycles -> conflict_cnt goes 1,2,3,3,3; conflict stays 1 throughout, then drops to 0 one cycle after the conflicts stop.

Source files
------------

// File: rtl/y86_regs_pkg.sv
// Shared Y86 register-file constants: register IDs and default sizing.
package y86_regs_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  // Architectural register IDs at the default ID width.
  localparam logic [DEF_ADDR_W-1:0] REG_EAX = 3'd0;
  localparam logic [DEF_ADDR_W-1:0] REG_ECX = 3'd1;
  localparam logic [DEF_ADDR_W-1:0] REG_EDX = 3'd2;
  localparam logic [DEF_ADDR_W-1:0] REG_EBX = 3'd3;
  localparam logic [DEF_ADDR_W-1:0] REG_ESP = 3'd4;
  localparam logic [DEF_ADDR_W-1:0] REG_EBP = 3'd5;
  localparam logic [DEF_ADDR_W-1:0] REG_ESI = 3'd6;
  localparam logic [DEF_ADDR_W-1:0] REG_EDI = 3'd7;

  // "No register" marker. It only acts as a real "none" when NREGS leaves
  // the all-ones ID unimplemented (e.g. ADDR_W=4, NREGS=15).
  localparam logic [DEF_ADDR_W-1:0] RNONE = '1;

endpackage

// File: rtl/wb_port_decode.sv
// One-hot decode of a write-back port; IDs at or above NREGS produce no enable.
module wb_port_decode
  import y86_regs_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 8
) (
  input  logic [ADDR_W-1:0] dst,
  input  logic              req,
  output logic [NREGS-1:0]  en
);

  // Only implemented IDs get an enable bit, so "none" IDs fall out naturally.
  always_comb begin
    en = '0;
    for (int i = 0; i < NREGS; i++) begin
      en[i] = req && (dst == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Y86 write-back register file: two write ports (E, M) with same-destination
// priority, two combinational read ports with optional write-first bypass,
// and a saturating counter of same-destination write conflicts.
module regfile_wb
  import y86_regs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 8,
  parameter int PRIO_M = 1,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dstE,
  input  logic              reqE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic              reqM,
  input  logic [DATA_W-1:0] valM,
  input  logic [ADDR_W-1:0] srcA,
  output logic [DATA_W-1:0] valA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valB,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [NREGS-1:0]  en_e;
  logic [NREGS-1:0]  en_m;
  logic [NREGS-1:0]  win_e;
  logic [NREGS-1:0]  win_m;
  logic              conflict_now;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] nxt  [NREGS];

  wb_port_decode #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_dec_e (
    .dst (dstE),
    .req (reqE),
    .en  (en_e)
  );

  wb_port_decode #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_dec_m (
    .dst (dstM),
    .req (reqM),
    .en  (en_m)
  );

  // Resolve per-register winners and the value each register will hold next.
  always_comb begin
    conflict_now = |(en_e & en_m);
    if (PRIO_M != 0) begin
      win_m = en_m;
      win_e = en_e & ~en_m;
    end else begin
      win_e = en_e;
      win_m = en_m & ~en_e;
    end
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = regs[i];
      if (win_m[i]) nxt[i] = valM;
      else if (win_e[i]) nxt[i] = valE;
    end
  end

  // Register storage; writes presented during reset are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) regs[i] <= '0;
      else     regs[i] <= nxt[i];
    end
  end

  // Conflict pulse and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict_now) begin
      conflict <= 1'b1;
      if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end else begin
      conflict <= 1'b0;
    end
  end

  // Read ports: unimplemented IDs read 0; bypass shows the value about to commit.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == ADDR_W'(i)) valA = (BYPASS != 0) ? nxt[i] : regs[i];
      if (srcB == ADDR_W'(i)) valB = (BYPASS != 0) ? nxt[i] : regs[i];
    end
  end

endmodule
